sram64x8_ctrl: RTL and testbench

SRAM64X8_CTRL -- requirements
Module: sram64x8_ctrl

---
 rtl/sram64x8_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sram64x8_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram64x8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram64x8_ctrl
//  Brief    : Request/response front end for a 64x8 synchronous SRAM macro
//             with read, write, masked read-modify-write and power-up clear.
//  Revision : 1.0
// ============================================================================
module sram64x8_ctrl #(
    parameter bit         INIT_EN    = 1'b1,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       CE,
    input  logic       RSTB,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] req_wmask,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       init_done,
    output logic [5:0] sram_A,
    output logic [7:0] sram_I,
    output logic       sram_CSB,
    output logic       sram_WEB,
    output logic       sram_OEB,
    input  logic [7:0] sram_O
);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_ISSUE  = 3'd2,
        ST_RD_CAPT   = 3'd3,
        ST_WR_ISSUE  = 3'd4,
        ST_RMW_ISSUE = 3'd5,
        ST_RMW_CAPT  = 3'd6,
        ST_RMW_WR    = 3'd7
    } state_t;

    localparam logic [1:0] c_cmd_read  = 2'b00;
    localparam logic [1:0] c_cmd_write = 2'b01;
    localparam logic [1:0] c_cmd_rmw   = 2'b10;
    localparam state_t     c_rst_state = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic       c_rst_done  = !INIT_EN;

    state_t     r_state;
    logic [5:0] r_cnt;
    logic [5:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_mask;
    logic       w_accept;

    assign req_ready = (r_state == ST_IDLE) && !rsp_valid;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            r_state   <= c_rst_state;
            init_done <= c_rst_done;
            r_cnt     <= 6'd0;
            r_addr    <= 6'd0;
            r_wdata   <= 8'd0;
            r_mask    <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            sram_A    <= 6'd0;
            sram_I    <= 8'd0;
            sram_CSB  <= 1'b1;
            sram_WEB  <= 1'b1;
            sram_OEB  <= 1'b1;
        end else begin
            // Pins fall back to idle unless a state below issues an access.
            sram_CSB <= 1'b1;
            sram_WEB <= 1'b1;
            sram_OEB <= 1'b1;
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (r_state)
                ST_INIT: begin
                    // The last clear write (A=63) is on the pins: leave next edge.
                    if (!sram_CSB && (sram_A == 6'd63)) begin
                        r_state   <= ST_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        sram_A   <= r_cnt;
                        sram_I   <= INIT_VALUE;
                        sram_CSB <= 1'b0;
                        sram_WEB <= 1'b0;
                        r_cnt    <= r_cnt + 6'd1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_mask  <= req_wmask;
                        case (req_cmd)
                            c_cmd_read: begin
                                sram_A   <= req_addr;
                                sram_CSB <= 1'b0;
                                sram_OEB <= 1'b0;
                                r_state  <= ST_RD_ISSUE;
                            end
                            c_cmd_write: begin
                                sram_A   <= req_addr;
                                sram_I   <= req_wdata;
                                sram_CSB <= 1'b0;
                                sram_WEB <= 1'b0;
                                r_state  <= ST_WR_ISSUE;
                            end
                            c_cmd_rmw: begin
                                sram_A   <= req_addr;
                                sram_CSB <= 1'b0;
                                sram_OEB <= 1'b0;
                                r_state  <= ST_RMW_ISSUE;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_CAPT;
                end
                ST_RD_CAPT: begin
                    rsp_rdata <= sram_O;
                    rsp_valid <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_WR_ISSUE: begin
                    r_state <= ST_IDLE;
                end
                ST_RMW_ISSUE: begin
                    r_state <= ST_RMW_CAPT;
                end
                ST_RMW_CAPT: begin
                    // Merge only once sram_O holds the data of the issue cycle.
                    sram_A   <= r_addr;
                    sram_I   <= (sram_O & ~r_mask) | (r_wdata & r_mask);
                    sram_CSB <= 1'b0;
                    sram_WEB <= 1'b0;
                    r_state  <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram64x8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram64x8_ctrl
//  Brief    : Directed scoreboard bench for sram64x8_ctrl with an SRAM model.
//  Revision : 1.0
// ============================================================================
module tb_sram64x8_ctrl;

    localparam logic [7:0] c_init_v = 8'h5A;

    logic       CE = 1'b0;
    logic       RSTB = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_cmd = 2'b00;
    logic [5:0] req_addr = 6'd0;
    logic [7:0] req_wdata = 8'd0;
    logic [7:0] req_wmask = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic [5:0] sram_A;
    logic [7:0] sram_I;
    logic       sram_CSB;
    logic       sram_WEB;
    logic       sram_OEB;
    logic [7:0] sram_O;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int wr9_cnt  = 0;
    logic [7:0] mem [64];
    logic [7:0] exp_q [$];

    always #5 CE = ~CE;

    sram64x8_ctrl #(
        .INIT_EN    (1'b1),
        .INIT_VALUE (c_init_v)
    ) dut (
        .CE        (CE),
        .RSTB      (RSTB),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_A    (sram_A),
        .sram_I    (sram_I),
        .sram_CSB  (sram_CSB),
        .sram_WEB  (sram_WEB),
        .sram_OEB  (sram_OEB),
        .sram_O    (sram_O)
    );

    // SRAM macro model: read data appears after the edge and holds until the next read.
    always @(posedge CE) begin
        if (!sram_CSB) begin
            acc_cnt++;
            if (!sram_WEB) begin
                mem[sram_A] <= sram_I;
                if (sram_A == 6'd9) wr9_cnt++;
            end
            if (!sram_OEB) sram_O <= mem[sram_A];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: one pop per response handshake.
    always @(negedge CE) begin
        if (RSTB && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got %0h expected no response", rsp_rdata);
            end else begin
                check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
        end
        if (!sram_CSB && !sram_WEB && !sram_OEB) begin
            n_checks++;
            $display("FAIL pin_conflict: got CSB/WEB/OEB=000 expected never");
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge CE);
        while (!req_ready && n < 300) begin
            @(negedge CE);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] m);
        wait_ready();
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        @(posedge CE);
        #1;
        req_valid = 1'b0;
        req_cmd   = ~cmd;
        req_addr  = ~a;
        req_wdata = ~d;
        req_wmask = ~m;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int a;
        int n;
        @(negedge CE);
        check("rst_pins", 32'({sram_CSB, sram_WEB, sram_OEB}), 32'(3'b111));
        check("rst_addr", 32'(sram_A), 32'd0);
        check("rst_wdata", 32'(sram_I), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        #12 RSTB = 1'b1;

        for (int i = 0; i < 64; i++) begin
            @(negedge CE);
            check("init_seq", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB, sram_I}),
                  32'({6'(i), 3'b001, c_init_v}));
        end
        @(negedge CE);
        check("init_done", 32'(init_done), 32'd1);
        check("init_exit_pins", 32'({sram_CSB, sram_WEB, sram_OEB}), 32'(3'b111));
        check("init_exit_ready", 32'(req_ready), 32'd1);

        exp_q.push_back(c_init_v);
        issue(2'b00, 6'd0, 8'h00, 8'h00);
        exp_q.push_back(c_init_v);
        issue(2'b00, 6'd63, 8'h00, 8'h00);

        issue(2'b01, 6'h15, 8'h3C, 8'h00);
        @(negedge CE);
        check("wr_pins", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB, sram_I}),
              32'({6'h15, 3'b001, 8'h3C}));
        @(negedge CE);
        check("wr_idle_next", 32'(req_ready), 32'd1);

        exp_q.push_back(8'h3C);
        issue(2'b00, 6'h15, 8'h00, 8'h00);
        @(negedge CE);
        check("rd_issue_pins", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB}), 32'({6'h15, 3'b010}));
        check("rd_lat_k1", 32'(rsp_valid), 32'd0);
        @(negedge CE);
        check("rd_capt_pins", 32'({sram_CSB, sram_WEB, sram_OEB}), 32'(3'b111));
        check("rd_lat_k2", 32'(rsp_valid), 32'd0);
        @(negedge CE);
        check("rd_lat_valid", 32'(rsp_valid), 32'd1);
        check("rd_busy_ready", 32'(req_ready), 32'd0);
        @(negedge CE);
        check("rd_pulse_end", 32'(rsp_valid), 32'd0);

        issue(2'b01, 6'd7, 8'hF0, 8'h00);
        issue(2'b10, 6'd7, 8'h0F, 8'h3C);
        @(negedge CE);
        check("rmw_rd_pins", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB}), 32'({6'd7, 3'b010}));
        @(negedge CE);
        check("rmw_capt_pins", 32'({sram_CSB, sram_WEB, sram_OEB}), 32'(3'b111));
        @(negedge CE);
        check("rmw_wr_pins", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB, sram_I}),
              32'({6'd7, 3'b001, 8'hCC}));
        @(negedge CE);
        check("rmw_idle_k3", 32'(req_ready), 32'd1);
        exp_q.push_back(8'hCC);
        issue(2'b00, 6'd7, 8'h00, 8'h00);

        wait_ready();
        a = acc_cnt;
        issue(2'b11, 6'h20, 8'hAA, 8'hFF);
        repeat (3) @(negedge CE);
        check("rsvd_no_access", 32'(acc_cnt), 32'(a));
        check("rsvd_no_rsp", 32'(rsp_valid), 32'd0);
        check("rsvd_idle", 32'(req_ready), 32'd1);
        exp_q.push_back(c_init_v);
        issue(2'b00, 6'h20, 8'h00, 8'h00);

        wait_ready();
        @(posedge CE);
        #1 rsp_ready = 1'b0;
        exp_q.push_back(8'h3C);
        issue(2'b00, 6'h15, 8'h00, 8'h00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge CE);
            n++;
        end
        check("bp_rsp_arrives", 32'(rsp_valid), 32'd1);
        a = acc_cnt;
        req_valid = 1'b1;
        req_cmd   = 2'b01;
        req_addr  = 6'h15;
        req_wdata = 8'h00;
        repeat (5) begin
            @(negedge CE);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_rdata), 32'h3C);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check("bp_no_access", 32'(acc_cnt), 32'(a));
        @(posedge CE);
        #1 rsp_ready = 1'b1;
        @(negedge CE);
        @(negedge CE);
        check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        check("bp_ready_after", 32'(req_ready), 32'd1);

        issue(2'b01, 6'd9, 8'h77, 8'h00);
        issue(2'b10, 6'd9, 8'hFF, 8'hFF);
        @(posedge CE);
        #2;
        a = wr9_cnt;
        RSTB = 1'b0;
        #1;
        check("rst_mid_pins", 32'({sram_CSB, sram_WEB, sram_OEB}), 32'(3'b111));
        check("rst_mid_addr", 32'(sram_A), 32'd0);
        check("rst_mid_wdata", 32'(sram_I), 32'd0);
        check("rst_mid_done", 32'(init_done), 32'd0);
        repeat (2) @(posedge CE);
        #2;
        check("rst_mid_no_write", 32'(wr9_cnt), 32'(a));
        check("rst_mid_mem", 32'(mem[9]), 32'h77);
        RSTB = 1'b1;
        @(posedge CE);
        #1;
        check("reinit_addr0", 32'({sram_A, sram_CSB, sram_WEB, sram_OEB, sram_I}),
              32'({6'd0, 3'b001, c_init_v}));
        n = 0;
        while (!init_done && n < 100) begin
            @(negedge CE);
            n++;
        end
        check("reinit_done", 32'(init_done), 32'd1);
        exp_q.push_back(c_init_v);
        issue(2'b00, 6'd9, 8'h00, 8'h00);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CE);
            n++;
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
